// File: rtl/reporte_ciclos.sv
// reporte_ciclos: on each halt, captures the cycle count and sends it over UART as
// a header byte followed by the zero-extended count, most significant byte first.
module reporte_ciclos #(
  parameter int CONTADOR_LENGTH = 11,
  parameter int DATA_LENGTH = 8,
  parameter logic [DATA_LENGTH-1:0] HEADER_BYTE = 8'hA5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [CONTADOR_LENGTH-1:0] i_cuenta,
  input  logic                       i_halt,
  input  logic                       i_tx_done,
  output logic                       o_tx_start,
  output logic [DATA_LENGTH-1:0]     o_tx_data,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int NUM_BYTES = (CONTADOR_LENGTH + 7) / 8;
  localparam int CW = NUM_BYTES * 8;
  localparam int IW = $clog2(NUM_BYTES + 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cuenta;
  logic [IW-1:0] idx;
  logic [DATA_LENGTH-1:0] next_byte;
  // idx counts frame bytes already sent: 0 is the header, k is count byte k (MSB first)
  always_comb begin
    next_byte = HEADER_BYTE;
    for (int k = 1; k <= NUM_BYTES; k++)
      if (int'(idx) + 1 == k) next_byte = cuenta[(NUM_BYTES-k)*8 +: DATA_LENGTH];
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state      <= IDLE;
      cuenta     <= '0;
      idx        <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else
      case (state)
        IDLE:
          if (i_halt) begin
            cuenta     <= CW'(i_cuenta);
            idx        <= '0;
            o_tx_start <= 1'b1;
            o_tx_data  <= HEADER_BYTE;
            o_busy     <= 1'b1;
            state      <= SEND;
          end
        SEND: begin
          o_tx_start <= 1'b0;
          state      <= WAIT_TX;
        end
        WAIT_TX:
          if (i_tx_done) begin
            if (int'(idx) == NUM_BYTES) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              idx        <= idx + IW'(1);
              o_tx_data  <= next_byte;
              o_tx_start <= 1'b1;
              state      <= SEND;
            end
          end
        default:
          if (!i_halt) begin
            o_done <= 1'b0;
            state  <= IDLE;
          end
      endcase
endmodule

// File: doc/reporte_ciclos.md
REPORTE_CICLOS -- requirements
Module: reporte_ciclos

Interface
REQ-001 Parameter CONTADOR_LENGTH, default 11: width of the cycle count input; legal range 1..32.
REQ-002 Parameter DATA_LENGTH, default 8: UART byte width; fixed at 8.
REQ-003 Parameter HEADER_BYTE, default 8'hA5: marker byte sent before the count bytes.
REQ-004 i_clock  input  1  single clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_cuenta  input  CONTADOR_LENGTH  running cycle count from the upstream cycle counter.
REQ-007 i_halt  input  1  processor halted (level); requests a report.
REQ-008 i_tx_done  input  1  one-cycle pulse from the UART transmitter: current byte finished.
REQ-009 o_tx_start  output  1  one-cycle pulse: UART shall load o_tx_data.
REQ-010 o_tx_data  output  DATA_LENGTH  byte being transmitted.
REQ-011 o_busy  output  1  high from capture until the last byte's i_tx_done.
REQ-012 o_done  output  1  report complete, held until i_halt falls.

Function
REQ-013 NUM_BYTES SHALL be ceil(CONTADOR_LENGTH/8); the captured count SHALL be zero-extended to NUM_BYTES*8 bits.
REQ-014 States SHALL be IDLE, SEND, WAIT_TX, DONE; all outputs registered.
REQ-015 IDLE: if i_halt=1 at edge N, i_cuenta SHALL be latched at edge N, byte index cleared, state -> SEND; else stay IDLE.
REQ-016 SEND (one cycle): o_tx_start=1, o_busy=1; o_tx_data = HEADER_BYTE for index 0, else count byte; state -> WAIT_TX.
REQ-017 Count bytes SHALL be sent MSB byte first; total frame = 1 + NUM_BYTES bytes.
REQ-018 o_tx_data SHALL stay stable from the SEND cycle until the i_tx_done that ends that byte.
REQ-019 WAIT_TX: on i_tx_done=1, if more bytes remain index increments and state -> SEND; if last byte, state -> DONE, o_busy -> 0, o_done -> 1.
REQ-020 i_tx_done SHALL be ignored in IDLE, SEND and DONE states.
REQ-021 DONE: o_done=1 while i_halt=1; when i_halt=0, o_done -> 0 and state -> IDLE next edge.
REQ-022 Changes on i_cuenta after capture SHALL NOT affect the frame in progress.
REQ-023 i_halt falling during SEND/WAIT_TX SHALL NOT abort the frame; after the last byte, DONE exits on the first edge with i_halt=0.
REQ-024 A new report SHALL require i_halt to pass through 0 (one report per halt assertion).
REQ-025 Minimum byte period: 2 cycles (SEND, then WAIT_TX with i_tx_done); i_tx_done in the cycle right after SEND SHALL be accepted.

Reset
REQ-026 i_reset=1 SHALL immediately, without a clock edge, force state IDLE, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, index=0, captured count=0.
REQ-027 Reset mid-frame SHALL abandon the frame; no further o_tx_start until a new capture.
REQ-028 If i_halt=1 at reset release, a capture SHALL occur at the first rising edge after release.

Verification
REQ-029 i_cuenta=11'h5A3, i_halt rises, i_tx_done 3 cycles after each start -> 3 start pulses, bytes A5, 05, A3; o_busy high throughout; o_done=1 after third i_tx_done.
REQ-030 i_cuenta incremented every cycle during the frame -> transmitted bytes equal the value at capture edge only.
REQ-031 i_halt held high after DONE for 20 cycles -> no second frame; drop then raise i_halt -> exactly one new frame.
REQ-032 i_reset pulsed during WAIT_TX of byte 2 -> outputs zero asynchronously, no further o_tx_start; i_halt still high -> new frame starts with A5 at the first edge after release.
REQ-033 Spurious i_tx_done pulses in IDLE and DONE -> no state change, no o_tx_start.
REQ-034 CONTADOR_LENGTH=17, i_cuenta=17'h1ABCD, back-to-back i_tx_done -> bytes A5, 01, AB, CD, one byte every 2 cycles.
